// File: rtl/eth_rx_checker.sv
// Ethernet 10/100 RX frame checker: nibble count, CRC-32 residue, DA match,
// end-of-frame status word and saturating per-error statistics.
module eth_rx_stat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             rx_clk,
  input  logic             res,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge rx_clk or negedge res)
    if (!res)                   cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && !(&cnt))    cnt <= cnt + 1'b1;
endmodule

module eth_rx_checker #(
  parameter int N_ADR = 4,
  parameter int CNT_W = 16
) (
  input  logic                  rx_clk,
  input  logic                  res,
  input  logic [3:0]            rxd,
  input  logic                  rx_dv,
  input  logic                  rx_er,
  input  logic                  rip,
  input  logic                  full_duplex,
  input  logic                  promisc,
  input  logic [48*N_ADR-1:0]   adr_tab,
  input  logic [N_ADR-1:0]      adr_en,
  input  logic [47:0]           mult_adr,
  input  logic [2:0]            acc_en,
  input  logic [9:0]            min_len,
  input  logic [12:0]           max_len,
  input  logic [5:0]            ignore,
  input  logic                  stat_clr,
  output logic [5:0]            frame_errors,
  output logic [5:0]            frame_errors_masked,
  output logic [N_ADR+2:0]      adr_hit,
  output logic                  status_valid,
  output logic                  frame_ok,
  output logic [7*CNT_W-1:0]    stats
);
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_RES  = 32'hC704DD7B;
  localparam logic [47:0] BCAST    = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] PAUSE    = 48'h0180C2000001;

  logic             rip_d, dv_d, rxer_acc, eof, fb;
  logic [17:0]      cnt;
  logic [31:0]      crc, crc_nxt;
  logic [47:0]      dest;
  logic [N_ADR-1:0] ent_hit;
  logic             bc_hit, mc_hit, pa_hit, short_frm, acc_hit;
  logic [5:0]       err_nxt;
  logic [6:0]       st_inc;

  assign eof = !rip && rip_d;

  // Four serial CRC steps per nibble, rxd[0] shifted in first.
  always_comb begin
    fb      = 1'b0;
    crc_nxt = crc;
    for (int b = 0; b < 4; b++) begin
      fb      = crc_nxt[31] ^ rxd[b];
      crc_nxt = {crc_nxt[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
  end

  always_ff @(posedge rx_clk or negedge res)
    if (!res) begin
      rip_d    <= 1'b0;
      dv_d     <= 1'b0;
      rxer_acc <= 1'b0;
      cnt      <= '0;
      crc      <= '1;
      dest     <= '0;
    end else begin
      rip_d <= rip;
      dv_d  <= rx_dv;
      // Carrier start opens a new accumulation window; a coincident error still sets.
      if (rx_dv && rx_er)      rxer_acc <= 1'b1;
      else if (rx_dv && !dv_d) rxer_acc <= 1'b0;
      if (!rip) begin
        cnt <= '0;
        crc <= '1;
      end else begin
        if (!(&cnt)) cnt <= cnt + 1'b1;
        crc <= crc_nxt;
        // Low nibble of each DA byte arrives first.
        for (int k = 0; k < 12; k++)
          if (cnt == 18'(k)) dest[47-4*(k^1) -: 4] <= rxd;
      end
    end

  genvar gi;
  generate
    for (gi = 0; gi < N_ADR; gi++) begin : g_ent
      assign ent_hit[gi] = (adr_tab[48*gi +: 48] == dest);
    end
  endgenerate

  assign bc_hit    = (dest == BCAST);
  assign pa_hit    = (dest == PAUSE);
  assign mc_hit    = (dest == mult_adr);
  assign short_frm = (cnt < 18'd12);
  assign acc_hit   = (|(ent_hit & adr_en)) | (bc_hit & acc_en[0]) |
                     (pa_hit & acc_en[1] & full_duplex) | (mc_hit & acc_en[2]);

  assign err_nxt = {rxer_acc,
                    cnt[0],
                    crc != CRC_RES,
                    cnt < 18'({min_len, 1'b0}),
                    cnt > 18'({max_len, 1'b0}),
                    !promisc && (short_frm || !acc_hit)};

  always_ff @(posedge rx_clk or negedge res)
    if (!res) begin
      status_valid <= 1'b0;
      frame_errors <= '0;
      adr_hit      <= '0;
    end else begin
      status_valid <= eof;
      if (eof) begin
        frame_errors <= err_nxt;
        adr_hit      <= short_frm ? '0 : {pa_hit, mc_hit, bc_hit, ent_hit};
      end
    end

  assign frame_errors_masked = frame_errors & ~ignore;
  assign frame_ok            = status_valid && !(|frame_errors_masked);

  // Counter order matches frame_errors bit order, good counter on top.
  assign st_inc = {frame_ok, frame_errors & {6{status_valid}}};

  generate
    for (gi = 0; gi < 7; gi++) begin : g_stat
      eth_rx_stat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .rx_clk (rx_clk),
        .res    (res),
        .clr    (stat_clr),
        .inc    (st_inc[gi]),
        .cnt    (stats[CNT_W*gi +: CNT_W])
      );
    end
  endgenerate
endmodule

// File: tb/tb_eth_rx_checker.sv
// Directed bench for eth_rx_checker; FCS generated with a reflected byte-wise CRC-32.
module tb_eth_rx_checker;
  localparam int N_ADR = 4;
  localparam int CNT_W = 2;
  localparam logic [47:0] E0 = 48'h020000000010, E1 = 48'h020000000011;
  localparam logic [47:0] E2 = 48'h02AABBCCDD02, E3 = 48'h020000000013;
  localparam logic [47:0] PAUSE = 48'h0180C2000001, MC = 48'h01005E000001;
  localparam logic [47:0] UNK = 48'h00123456789A;

  logic rx_clk = 1'b0, res = 1'b0;
  logic [3:0] rxd;
  logic rx_dv, rx_er, rip, full_duplex, promisc, stat_clr;
  logic [48*N_ADR-1:0] adr_tab;
  logic [N_ADR-1:0] adr_en;
  logic [47:0] mult_adr;
  logic [2:0] acc_en;
  logic [9:0] min_len;
  logic [12:0] max_len;
  logic [5:0] ignore, frame_errors, frame_errors_masked;
  logic [N_ADR+2:0] adr_hit;
  logic status_valid, frame_ok;
  logic [7*CNT_W-1:0] stats;

  int checks = 0, failures = 0;
  logic [7:0] frm [0:2047];
  int frm_len;

  eth_rx_checker #(.N_ADR(N_ADR), .CNT_W(CNT_W)) dut (
    .rx_clk(rx_clk), .res(res), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er), .rip(rip),
    .full_duplex(full_duplex), .promisc(promisc), .adr_tab(adr_tab), .adr_en(adr_en),
    .mult_adr(mult_adr), .acc_en(acc_en), .min_len(min_len), .max_len(max_len),
    .ignore(ignore), .stat_clr(stat_clr), .frame_errors(frame_errors),
    .frame_errors_masked(frame_errors_masked), .adr_hit(adr_hit),
    .status_valid(status_valid), .frame_ok(frame_ok), .stats(stats)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rx_clk); #1;
  endtask

  // Counters packed {good, rx_er, align, fcs, min, max, adr}.
  function automatic logic [63:0] sw(input int g, input int rx, input int al, input int fc,
                                     input int mn, input int mx, input int ad);
    return 64'({2'(g), 2'(rx), 2'(al), 2'(fc), 2'(mn), 2'(mx), 2'(ad)});
  endfunction

  task automatic build_frame(input logic [47:0] da, input int len);
    logic [31:0] c;
    for (int i = 0; i < 6; i++) frm[i] = da[47-8*i -: 8];
    for (int i = 6; i < 12; i++) frm[i] = 8'(8'h20 + i);
    for (int i = 12; i < len - 4; i++) frm[i] = 8'(i * 37 + 5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm[len-4+i] = c[8*i +: 8];
    frm_len = len;
  endtask

  task automatic send_frame(input string tag, input int flip_nib, input int extra,
                            input bit pre_er, input bit clr_at_status,
                            input logic [5:0] exp_err, input logic [N_ADR+2:0] exp_hit,
                            input logic exp_ok, input logic [63:0] exp_stats);
    logic [7:0] b;
    rx_dv = 1'b1;
    rip   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rxd   = (i == 15) ? 4'hD : 4'h5;
      rx_er = pre_er && (i == 3);
      tick();
    end
    rx_er = 1'b0;
    rip   = 1'b1;
    for (int k = 0; k < 2*frm_len + extra; k++) begin
      b   = (k/2 < frm_len) ? frm[k/2] : 8'h00;
      rxd = (k % 2 == 1) ? b[7:4] : b[3:0];
      if (k == flip_nib) rxd ^= 4'h1;
      tick();
    end
    rip   = 1'b0;
    rx_dv = 1'b0;
    rxd   = 4'h0;
    @(negedge rx_clk);
    check({tag, "/sv_E"}, status_valid, 1'b0);
    @(negedge rx_clk);
    check({tag, "/sv"}, status_valid, 1'b1);
    check({tag, "/err"}, frame_errors, exp_err);
    check({tag, "/masked"}, frame_errors_masked, exp_err & ~ignore);
    check({tag, "/hit"}, adr_hit, exp_hit);
    check({tag, "/ok"}, frame_ok, exp_ok);
    if (clr_at_status) stat_clr = 1'b1;
    @(negedge rx_clk);
    stat_clr = 1'b0;
    check({tag, "/sv_E2"}, status_valid, 1'b0);
    check({tag, "/err_hold"}, frame_errors, exp_err);
    check({tag, "/stats"}, stats, exp_stats);
  endtask

  initial begin
    rxd = '0; rx_dv = 0; rx_er = 0; rip = 0; full_duplex = 0; promisc = 0; stat_clr = 0;
    adr_tab = {E3, E2, E1, E0}; adr_en = 4'b0100; mult_adr = MC; acc_en = 3'b010;
    min_len = 10'd64; max_len = 13'd1518; ignore = '0;
    repeat (3) @(posedge rx_clk);
    #1;
    check("rst/err", frame_errors, 6'h0);
    check("rst/hit", adr_hit, '0);
    check("rst/sv", status_valid, 1'b0);
    check("rst/ok", frame_ok, 1'b0);
    check("rst/stats", stats, '0);
    res = 1'b1;
    tick();

    build_frame(E2, 64);
    send_frame("good64", -1, 0, 0, 0, 6'b000000, 7'b0000100, 1, sw(1,0,0,0,0,0,0));
    send_frame("fcs", 60, 0, 0, 0, 6'b001000, 7'b0000100, 0, sw(1,0,0,1,0,0,0));
    ignore = 6'b001000;
    send_frame("fcs_ign", 60, 0, 0, 0, 6'b001000, 7'b0000100, 1, sw(2,0,0,2,0,0,0));
    ignore = '0;
    build_frame(E2, 63);
    send_frame("min63", -1, 0, 0, 0, 6'b000100, 7'b0000100, 0, sw(2,0,0,2,1,0,0));
    build_frame(E2, 1519);
    send_frame("max1519", -1, 0, 0, 0, 6'b000010, 7'b0000100, 0, sw(2,0,0,2,1,1,0));
    build_frame(E2, 1518);
    send_frame("len1518", -1, 0, 0, 0, 6'b000000, 7'b0000100, 1, sw(3,0,0,2,1,1,0));
    build_frame(E2, 64);
    send_frame("align129", -1, 1, 0, 0, 6'b011000, 7'b0000100, 0, sw(3,0,1,3,1,1,0));

    build_frame(PAUSE, 64);
    send_frame("pause_hd", -1, 0, 0, 0, 6'b000001, 7'b1000000, 0, sw(3,0,1,3,1,1,1));
    full_duplex = 1'b1;
    send_frame("pause_fd", -1, 0, 0, 0, 6'b000000, 7'b1000000, 1, sw(3,0,1,3,1,1,1));
    full_duplex = 1'b0;
    build_frame(MC, 64);
    send_frame("mc_dis", -1, 0, 0, 0, 6'b000001, 7'b0100000, 0, sw(3,0,1,3,1,1,2));
    build_frame(UNK, 64);
    promisc = 1'b1;
    send_frame("promisc", -1, 0, 0, 0, 6'b000000, 7'b0000000, 1, sw(3,0,1,3,1,1,2));
    promisc = 1'b0;
    build_frame(E1, 64);
    send_frame("ent_dis", -1, 0, 0, 0, 6'b000001, 7'b0000010, 0, sw(3,0,1,3,1,1,3));

    build_frame(E2, 64);
    send_frame("pre_rxer", -1, 0, 1, 0, 6'b100000, 7'b0000100, 0, sw(3,1,1,3,1,1,3));
    send_frame("clean", -1, 0, 0, 0, 6'b000000, 7'b0000100, 1, sw(3,1,1,3,1,1,3));

    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("stat_clr", stats, '0);
    for (int n = 1; n <= 4; n++)
      send_frame($sformatf("sat%0d", n), 60, 0, 0, 0, 6'b001000, 7'b0000100, 0,
                 sw(0,0,0,(n > 3) ? 3 : n,0,0,0));
    send_frame("clr_coinc", 60, 0, 0, 1, 6'b001000, 7'b0000100, 0, sw(0,0,0,0,0,0,0));

    // Reset in the middle of a frame: no status for the truncated frame.
    rx_dv = 1'b1;
    rip   = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rxd = 4'(k);
      tick();
    end
    res = 1'b0;
    #1;
    check("midrst/err", frame_errors, 6'h0);
    check("midrst/hit", adr_hit, '0);
    rip   = 1'b0;
    rx_dv = 1'b0;
    tick();
    res = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge rx_clk);
      check($sformatf("midrst/sv%0d", i), status_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
